cv32e40p_tmr_fault_manager: RTL and testbench
=============================================

# cv32e40p_tmr_fault_manager

Sequential supervisor for the triple-modular-redundant (TMR) core datapath. It consumes the per-replica mismatch flags produced by the majority voters and keeps a leaky-bucket error score per replica. When a replica's score reaches a threshold, it requests and handshakes a resynchronisation of that replica. It raises a sticky fatal flag on uncorrectable votes or on repeated resynchronisation.

## Interface
Parameters:
- CNT_W, 4: width of each per-replica error score counter.
- THRESH, 8: score that triggers resynchronisation; 1 ≤ THRESH ≤ 2^CNT_W−1.
- DECAY_PERIOD, 64: number of consecutive error-free valid votes per score decrement; ≥ 2.
- MAX_RESYNC, 4: total resynchronisations allowed before fatal; ≥ 1, fits 8 bits.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- vote_valid_i, input, 1: the voter flags below are meaningful this cycle.
- err_detected_i, input, 3: bit k set = replica k disagreed with the majority (bit0 = replica 1).
- err_uncorrectable_i, input, 1: all three replicas differed.
- resync_ack_i, input, 1: the resync engine has finished the requested replica.
- resync_req_o, output, 3: one-hot request to resynchronise replica k; held until acknowledged.
- replica_mask_o, output, 3: replica excluded from voting; equals resync_req_o.
- fatal_o, output, 1: sticky unrecoverable fault.
- score_o, output, 3×CNT_W: current score of each replica, replica 1 in the LSBs.
- resync_cnt_o, output, 8: number of completed resynchronisations.
- state_o, output, 2: current state, encoded MONITOR=0, REQ=1, FATAL=2.

## Operation
- The FSM has three states: MONITOR, REQ and FATAL. Reset places it in MONITOR.
- In MONITOR:
  - A cycle counts as a vote only when vote_valid_i=1. Flags are ignored when vote_valid_i=0.
  - On a vote, the score of each replica whose flag bit is set increments by 1. Scores saturate at 2^CNT_W−1.
  - The decay counter counts error-free votes. An error-free vote has err_detected_i=0 and err_uncorrectable_i=0.
  - Any erroneous vote clears the decay counter.
  - When the decay counter reaches DECAY_PERIOD−1 and the current vote is error-free, every nonzero score decrements by 1 and the decay counter clears.
  - Invalid cycles neither advance nor clear the decay counter.
  - MONITOR → REQ: if any registered score is ≥ THRESH, the FSM moves to REQ on the next edge. The target is the lowest-index replica with score ≥ THRESH, latched on that edge.
  - This check takes priority over counting. Votes arriving in the transition cycle are dropped.
- In REQ:
  - resync_req_o is one-hot on the target replica.
  - Scores and the decay counter are frozen. Voter flags are ignored, except err_uncorrectable_i.
  - On a cycle with resync_ack_i=1:
    - The target's score clears to 0.
    - The decay counter clears.
    - resync_cnt increments.
    - If the new resync_cnt equals MAX_RESYNC, the FSM moves to FATAL. Otherwise it returns to MONITOR.
  - The other replicas' scores are kept. If another replica is still ≥ THRESH, the FSM re-enters REQ one cycle later.
- FATAL is reached from any state when vote_valid_i=1 and err_uncorrectable_i=1. In the same cycle as an ack, this takes priority over the ack.
- FATAL is absorbing until rst_n is asserted.
  - fatal_o=1 and resync_req_o=0.
  - Scores are frozen.
- resync_ack_i is ignored outside REQ.
- resync_cnt_o saturates at 255.

## Timing
- All outputs are registered or are decodes of registered state. There is no combinational input-to-output path.
- Reset values:
  - state = MONITOR.
  - All scores, the decay counter and resync_cnt = 0.
  - resync_req_o = 0, replica_mask_o = 0, fatal_o = 0.
- Asserting rst_n mid-REQ drops the request immediately (asynchronous reset).
- Latencies:
  - A flag sampled at edge k is visible on score_o after edge k.
  - A score reaching THRESH at edge k gives resync_req_o high after edge k+1.
  - An ack sampled at edge m drops resync_req_o after edge m.
  - The uncorrectable flag at edge k gives fatal_o after edge k.
- Handshake: a request remains stable until it is acked. resync_ack_i may be held high for several cycles; only the first cycle counts, because the FSM leaves REQ. The request target never changes while in REQ.
- Simultaneous errors on two replicas both increment. If both reach THRESH together, the lower index is served first and the higher index follows after the ack.

## Test plan
- Threshold: THRESH=8. Apply 8 valid votes with err_detected_i=3'b010 → score_o[replica2]=8 after the 8th edge. resync_req_o=3'b010 one cycle later and held for 5 cycles with no ack. Ack → request drops, score=0, resync_cnt_o=1, state MONITOR.
- Decay: score1=3. Apply 64 error-free valid votes → score1=2. Apply 63 error-free votes, one error on replica 3, then 63 more error-free votes → score1 stays 2 and score3=1. Interleave invalid cycles → no effect on decay.
- Priority: drive err_detected_i=3'b011 for 8 votes → request 3'b001 first. After the ack, 3'b010 is requested one cycle after returning to MONITOR.
- Fatal on uncorrectable: in REQ, assert err_uncorrectable_i and resync_ack_i in the same cycle → fatal_o=1, resync_req_o=0, resync_cnt_o unchanged. Further flags are ignored until rst_n.
- Resync limit: MAX_RESYNC=4. Complete 4 resync handshakes → after the 4th ack, state_o=2 and fatal_o=1.
- Reset mid-operation: pull rst_n low asynchronously while resync_req_o=3'b100 and scores are nonzero → all outputs 0 immediately. After release, state MONITOR.

Source files
------------

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: leaky-bucket error scores per replica,
// resync request/ack handshake and sticky fatal detection.
module cv32e40p_tmr_fault_manager #(
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned THRESH       = 8,
    parameter int unsigned DECAY_PERIOD = 64,
    parameter int unsigned MAX_RESYNC   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vote_valid_i,
    input  logic [2:0]         err_detected_i,
    input  logic               err_uncorrectable_i,
    input  logic               resync_ack_i,
    output logic [2:0]         resync_req_o,
    output logic [2:0]         replica_mask_o,
    output logic               fatal_o,
    output logic [3*CNT_W-1:0] score_o,
    output logic [7:0]         resync_cnt_o,
    output logic [1:0]         state_o
);

    localparam int unsigned DW = $clog2(DECAY_PERIOD);

    localparam logic [CNT_W-1:0] SMAX  = '1;
    localparam logic [CNT_W-1:0] THR   = CNT_W'(THRESH);
    localparam logic [DW-1:0]    DLAST = DW'(DECAY_PERIOD - 1);
    localparam logic [7:0]       RMAX  = 8'(MAX_RESYNC);

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        REQ     = 2'd1,
        FATAL   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0][CNT_W-1:0]   score_q, score_d;
    logic [DW-1:0]           decay_q, decay_d;
    logic [2:0]              tgt_q, tgt_d;
    logic [7:0]              rcnt_q, rcnt_d;
    logic [2:0]              over;
    logic                    fatal_hit;
    logic                    err_free;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            over[k] = score_q[k] >= THR;
        end
    end

    assign fatal_hit = vote_valid_i & err_uncorrectable_i;
    assign err_free  = ~(|err_detected_i) & ~err_uncorrectable_i;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        decay_d = decay_q;
        tgt_d   = tgt_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            MONITOR: begin
                if (fatal_hit) begin
                    state_d = FATAL;
                end else if (|over) begin
                    // Threshold check wins; this cycle's vote is dropped.
                    state_d = REQ;
                    priority case (1'b1)
                        over[0]: tgt_d = 3'b001;
                        over[1]: tgt_d = 3'b010;
                        default: tgt_d = 3'b100;
                    endcase
                end else if (vote_valid_i) begin
                    for (int k = 0; k < 3; k++) begin
                        if (err_detected_i[k] && score_q[k] != SMAX) begin
                            score_d[k] = score_q[k] + 1'b1;
                        end
                    end
                    if (!err_free) begin
                        decay_d = '0;
                    end else if (decay_q == DLAST) begin
                        decay_d = '0;
                        for (int k = 0; k < 3; k++) begin
                            if (score_q[k] != '0) begin
                                score_d[k] = score_q[k] - 1'b1;
                            end
                        end
                    end else begin
                        decay_d = decay_q + 1'b1;
                    end
                end
            end
            REQ: begin
                if (fatal_hit) begin
                    state_d = FATAL;
                end else if (resync_ack_i) begin
                    for (int k = 0; k < 3; k++) begin
                        if (tgt_q[k]) begin
                            score_d[k] = '0;
                        end
                    end
                    decay_d = '0;
                    if (rcnt_q != 8'hFF) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                    state_d = (rcnt_d == RMAX) ? FATAL : MONITOR;
                end
            end
            FATAL: begin
                state_d = FATAL;
            end
            default: begin
                state_d = MONITOR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MONITOR;
            score_q <= '0;
            decay_q <= '0;
            tgt_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            decay_q <= decay_d;
            tgt_q   <= tgt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign resync_req_o   = (state_q == REQ) ? tgt_q : 3'b000;
    assign replica_mask_o = resync_req_o;
    assign fatal_o        = (state_q == FATAL);
    assign score_o        = score_q;
    assign resync_cnt_o   = rcnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Self-checking bench for cv32e40p_tmr_fault_manager:
// directed scenarios plus randomized traffic against a reference model.
module tb_cv32e40p_tmr_fault_manager;

    localparam int CW = 4;
    localparam int TH = 8;
    localparam int DP = 64;
    localparam int MR = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic            vote_valid_i;
    logic [2:0]      err_detected_i;
    logic            err_uncorrectable_i;
    logic            resync_ack_i;
    logic [2:0]      resync_req_o;
    logic [2:0]      replica_mask_o;
    logic            fatal_o;
    logic [3*CW-1:0] score_o;
    logic [7:0]      resync_cnt_o;
    logic [1:0]      state_o;

    cv32e40p_tmr_fault_manager #(
        .CNT_W(CW),
        .THRESH(TH),
        .DECAY_PERIOD(DP),
        .MAX_RESYNC(MR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vote_valid_i(vote_valid_i),
        .err_detected_i(err_detected_i),
        .err_uncorrectable_i(err_uncorrectable_i),
        .resync_ack_i(resync_ack_i),
        .resync_req_o(resync_req_o),
        .replica_mask_o(replica_mask_o),
        .fatal_o(fatal_o),
        .score_o(score_o),
        .resync_cnt_o(resync_cnt_o),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = monitoring, 1 = requesting, 2 = fatal
    int m_sc[3];
    int m_free;
    int m_cnt;
    int m_st;
    int m_tgt;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_sc[k] = 0;
        m_free = 0;
        m_cnt  = 0;
        m_st   = 0;
        m_tgt  = 0;
    endtask

    task automatic model_step();
        int first;
        first = -1;
        for (int k = 2; k >= 0; k--)
            if (m_sc[k] >= TH) first = k;
        if (m_st == 2) begin
            m_st = 2;
        end else if (vote_valid_i && err_uncorrectable_i) begin
            m_st = 2;
        end else if (m_st == 0) begin
            if (first >= 0) begin
                m_st  = 1;
                m_tgt = first;
            end else if (vote_valid_i) begin
                for (int k = 0; k < 3; k++)
                    if (err_detected_i[k] && m_sc[k] < SMAX) m_sc[k]++;
                if (err_detected_i == 3'b000) begin
                    m_free++;
                    if (m_free == DP) begin
                        m_free = 0;
                        for (int k = 0; k < 3; k++)
                            if (m_sc[k] > 0) m_sc[k]--;
                    end
                end else begin
                    m_free = 0;
                end
            end
        end else if (resync_ack_i) begin
            m_sc[m_tgt] = 0;
            m_free = 0;
            if (m_cnt < 255) m_cnt++;
            m_st = (m_cnt == MR) ? 2 : 0;
        end
    endtask

    task automatic check_all();
        int exp_req;
        exp_req = (m_st == 1) ? (1 << m_tgt) : 0;
        chk("state", state_o, m_st);
        chk("req", resync_req_o, exp_req);
        chk("mask", replica_mask_o, exp_req);
        chk("fatal", fatal_o, (m_st == 2) ? 1 : 0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("score%0d", k + 1), score_o[k*CW +: CW], m_sc[k]);
        chk("rcnt", resync_cnt_o, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        vote_valid_i        = 1'b0;
        err_detected_i      = 3'b000;
        err_uncorrectable_i = 1'b0;
        resync_ack_i        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic votes(input int n, input logic [2:0] e);
        for (int i = 0; i < n; i++) begin
            vote_valid_i   = 1'b1;
            err_detected_i = e;
            tick();
        end
        idle();
    endtask

    task automatic ack();
        resync_ack_i = 1'b1;
        tick();
        resync_ack_i = 1'b0;
    endtask

    // Each vote preceded by an invalid cycle carrying random flags
    task automatic sparse_votes(input int n, input logic [2:0] e);
        for (int i = 0; i < n; i++) begin
            vote_valid_i   = 1'b0;
            err_detected_i = 3'($urandom);
            resync_ack_i   = 1'($urandom);
            tick();
            resync_ack_i = 1'b0;
            votes(1, e);
        end
    endtask

    initial begin
        int rate;
        idle();
        rst_n = 1'b0;
        #12;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Threshold and handshake
        votes(8, 3'b010);
        chk("thr_score", score_o[CW +: CW], 8);
        chk("thr_noreq", resync_req_o, 0);
        tick();
        chk("thr_req", resync_req_o, 3'b010);
        for (int i = 0; i < 5; i++) tick();
        chk("thr_hold", resync_req_o, 3'b010);
        ack();
        chk("thr_drop", resync_req_o, 0);
        chk("thr_cnt", resync_cnt_o, 1);
        chk("thr_st", state_o, 0);

        // Decay, with invalid cycles interleaved
        votes(3, 3'b001);
        sparse_votes(64, 3'b000);
        chk("dec_1", score_o[0 +: CW], 2);
        sparse_votes(63, 3'b000);
        sparse_votes(1, 3'b100);
        sparse_votes(63, 3'b000);
        chk("dec_keep", score_o[0 +: CW], 2);
        chk("dec_s3", score_o[2*CW +: CW], 1);

        // Lower index served first
        do_reset();
        votes(8, 3'b011);
        tick();
        chk("pri_first", resync_req_o, 3'b001);
        ack();
        chk("pri_mon", state_o, 0);
        tick();
        chk("pri_second", resync_req_o, 3'b010);
        ack();

        // Uncorrectable beats a simultaneous ack
        votes(8, 3'b100);
        tick();
        chk("fat_req", resync_req_o, 3'b100);
        vote_valid_i        = 1'b1;
        err_uncorrectable_i = 1'b1;
        resync_ack_i        = 1'b1;
        tick();
        chk("fat_flag", fatal_o, 1);
        chk("fat_cnt", resync_cnt_o, 2);
        for (int i = 0; i < 6; i++) begin
            vote_valid_i        = 1'b1;
            err_detected_i      = 3'($urandom);
            err_uncorrectable_i = 1'($urandom);
            resync_ack_i        = 1'($urandom);
            tick();
        end
        idle();
        chk("fat_stick", state_o, 2);

        // Resync limit
        do_reset();
        for (int r = 0; r < MR; r++) begin
            votes(8, 3'b001);
            tick();
            ack();
        end
        chk("lim_st", state_o, 2);
        chk("lim_fatal", fatal_o, 1);

        // Asynchronous reset while requesting
        do_reset();
        votes(3, 3'b101);
        votes(5, 3'b100);
        tick();
        chk("rst_pre", resync_req_o, 3'b100);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_mon", state_o, 0);

        // Randomized traffic
        rate = 3;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) rate = $urandom_range(1, 12);
            vote_valid_i        = ($urandom % 4) != 0;
            err_detected_i      = (($urandom % rate) == 0) ? 3'($urandom) : 3'b000;
            err_uncorrectable_i = ($urandom % 500) == 0;
            resync_ack_i        = ($urandom % 4) == 0;
            tick();
            if (m_st == 2 && ($urandom % 10) == 0) do_reset();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
